// File: rtl/prop_monitor_if.sv
// Bundles the control inputs and verdict/diagnostic outputs of prop_monitor.
// The monitor is the slave; the stimulus side is the master.
interface prop_monitor_if #(
    parameter int CW = 8
) ();
    logic          en;
    logic          clear;
    logic          prop;
    logic          busy;
    logic          fail;
    logic [CW-1:0] fail_cycle;
    logic [CW-1:0] viol_cnt;
    logic [CW-1:0] cyc;

    modport master (
        output en, clear, prop,
        input  busy, fail, fail_cycle, viol_cnt, cyc
    );

    modport slave (
        input  en, clear, prop,
        output busy, fail, fail_cycle, viol_cnt, cyc
    );
endinterface

// File: rtl/prop_monitor.sv
// Runtime monitor for the single-bit prop safety output: tolerates up to LIMIT
// consecutive low samples, then latches a sticky FAIL with the failing cycle index.
module prop_monitor #(
    parameter int CW    = 8,
    parameter int LIMIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    prop_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_PENDING = 2'b10,
        ST_FAIL    = 2'b11
    } state_e;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    state_e        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [CW-1:0] low_cnt_q, low_cnt_d;
    logic [CW-1:0] viol_cnt_q, viol_cnt_d;
    logic [CW-1:0] fail_cycle_q, fail_cycle_d;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        low_cnt_d    = low_cnt_q;
        viol_cnt_d   = viol_cnt_q;
        fail_cycle_d = fail_cycle_q;

        if (mon.clear) begin
            state_d      = ST_IDLE;
            cyc_d        = '0;
            low_cnt_d    = '0;
            viol_cnt_d   = '0;
            fail_cycle_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mon.en) begin
                        state_d    = ST_ARMED;
                        cyc_d      = '0;
                        viol_cnt_d = '0;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    if (!mon.en) begin
                        // Disarm wins over a simultaneous low sample; it is not counted.
                        state_d   = ST_IDLE;
                        low_cnt_d = '0;
                    end else begin
                        cyc_d = sat_inc(cyc_q);
                        if (mon.prop) begin
                            state_d   = ST_ARMED;
                            low_cnt_d = '0;
                        end else begin
                            viol_cnt_d = sat_inc(viol_cnt_q);
                            if ((state_q == ST_ARMED && LIMIT == 0) ||
                                (state_q == ST_PENDING && low_cnt_q == LIMIT_C)) begin
                                state_d      = ST_FAIL;
                                fail_cycle_d = cyc_q;
                            end else if (state_q == ST_ARMED) begin
                                state_d   = ST_PENDING;
                                low_cnt_d = CW'(1);
                            end else begin
                                low_cnt_d = low_cnt_q + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            low_cnt_q    <= '0;
            viol_cnt_q   <= '0;
            fail_cycle_q <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            low_cnt_q    <= low_cnt_d;
            viol_cnt_q   <= viol_cnt_d;
            fail_cycle_q <= fail_cycle_d;
        end
    end

    assign mon.busy       = (state_q != ST_IDLE);
    assign mon.fail       = (state_q == ST_FAIL);
    assign mon.fail_cycle = fail_cycle_q;
    assign mon.viol_cnt   = viol_cnt_q;
    assign mon.cyc        = cyc_q;

endmodule

// File: tb/tb_prop_monitor.sv
// Directed bench for prop_monitor: three instances cover LIMIT=2, LIMIT=0 and a
// narrow CW=4 cycle index that saturates.
module tb_prop_monitor;

    logic clk;
    logic reset;

    int n_checks;
    int n_errors;

    prop_monitor_if #(.CW(8)) if_a ();
    prop_monitor_if #(.CW(8)) if_b ();
    prop_monitor_if #(.CW(4)) if_c ();

    prop_monitor #(.CW(8), .LIMIT(2)) u_a (.clk(clk), .reset(reset), .mon(if_a.slave));
    prop_monitor #(.CW(8), .LIMIT(0)) u_b (.clk(clk), .reset(reset), .mon(if_b.slave));
    prop_monitor #(.CW(4), .LIMIT(0)) u_c (.clk(clk), .reset(reset), .mon(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic en, input logic clr, input logic prop);
        if_a.en    = en;
        if_a.clear = clr;
        if_a.prop  = prop;
        tick();
    endtask

    task automatic check_a(input string tag, input int busy, input int fail,
                           input int fcyc, input int viol, input int cyc);
        check_val({tag, ".busy"}, int'(if_a.busy), busy);
        check_val({tag, ".fail"}, int'(if_a.fail), fail);
        check_val({tag, ".fail_cycle"}, int'(if_a.fail_cycle), fcyc);
        check_val({tag, ".viol_cnt"}, int'(if_a.viol_cnt), viol);
        check_val({tag, ".cyc"}, int'(if_a.cyc), cyc);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        if_a.en = 0; if_a.clear = 0; if_a.prop = 1;
        if_b.en = 0; if_b.clear = 0; if_b.prop = 1;
        if_c.en = 0; if_c.clear = 0; if_c.prop = 1;
        tick();
        tick();
        check_a("reset", 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        tick();
        check_a("idle_after_reset", 0, 0, 0, 0, 0);

        // Arm and run ten good edges in total.
        drive_a(1, 0, 1);
        check_a("armed", 1, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) drive_a(1, 0, 1);
        check_a("good_run", 1, 0, 0, 0, 9);

        // Tolerated low run at samples 3..4.
        drive_a(0, 0, 1);
        drive_a(1, 0, 1);
        for (int k = 0; k <= 5; k++) begin
            drive_a(1, 0, !(k == 3 || k == 4));
            if (k == 4) check_val("tol.pending_state", int'(u_a.state_q), 2);
        end
        check_val("tol.state", int'(u_a.state_q), 1);
        check_a("tol", 1, 0, 0, 2, 6);

        // Failing low run at samples 4..6.
        drive_a(0, 0, 1);
        drive_a(1, 0, 1);
        check_a("rearm", 1, 0, 0, 0, 0);
        for (int k = 0; k <= 6; k++) begin
            drive_a(1, 0, !(k >= 4));
            if (k == 5) check_val("lim.pre_fail", int'(if_a.fail), 0);
        end
        check_a("lim.fail", 1, 1, 6, 3, 7);
        for (int k = 0; k < 5; k++) begin
            drive_a(k[0], 0, k[1]);
            check_a("frozen", 1, 1, 6, 3, 7);
        end
        drive_a(0, 1, 0);
        check_a("clear", 0, 0, 0, 0, 0);

        // Disarm together with a low sample: sample not counted.
        drive_a(1, 0, 1);
        drive_a(1, 0, 1);
        drive_a(0, 0, 0);
        check_a("disarm_low", 0, 0, 0, 0, 1);

        // Clear together with the failing sample: never fails.
        drive_a(1, 0, 1);
        drive_a(1, 0, 0);
        drive_a(1, 0, 0);
        check_a("pre_clear_fail", 1, 0, 0, 2, 2);
        drive_a(1, 1, 0);
        check_a("clear_vs_fail", 0, 0, 0, 0, 0);
        drive_a(0, 0, 1);

        // LIMIT=0: a single low at sample 2 fails.
        if_b.en = 1; if_b.prop = 1;
        tick();
        for (int k = 0; k <= 2; k++) begin
            if_b.prop = (k != 2);
            tick();
            if (k == 1) check_val("l0.pre_fail", int'(if_b.fail), 0);
        end
        check_val("l0.fail", int'(if_b.fail), 1);
        check_val("l0.fail_cycle", int'(if_b.fail_cycle), 2);
        check_val("l0.viol_cnt", int'(if_b.viol_cnt), 1);

        // CW=4: cyc saturates at 15, failure records the saturated index.
        if_c.en = 1; if_c.prop = 1;
        tick();
        for (int k = 0; k < 20; k++) tick();
        check_val("sat.cyc", int'(if_c.cyc), 15);
        check_val("sat.fail_pre", int'(if_c.fail), 0);
        if_c.prop = 0;
        tick();
        check_val("sat.fail", int'(if_c.fail), 1);
        check_val("sat.fail_cycle", int'(if_c.fail_cycle), 15);
        check_val("sat.viol_cnt", int'(if_c.viol_cnt), 1);
        check_val("sat.cyc_frozen", int'(if_c.cyc), 15);

        // Asynchronous reset while PENDING.
        drive_a(1, 0, 1);
        drive_a(1, 0, 0);
        check_a("pend", 1, 0, 0, 1, 1);
        #2 reset = 1'b0;
        #1;
        check_a("async_reset", 0, 0, 0, 0, 0);
        check_val("async_reset.fail_b", int'(if_b.fail), 0);
        check_val("async_reset.fail_c", int'(if_c.fail), 0);
        if_a.prop = 1;
        #1 reset = 1'b1;
        tick();
        check_a("rearm_after_reset", 1, 0, 0, 0, 0);
        check_val("rearm_after_reset.state", int'(u_a.state_q), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/prop_monitor.md
# prop_monitor

Registered runtime monitor that sits directly downstream of the diagonal counter pair and consumes its single-bit `prop` safety output. When armed, it samples `prop` every clock and tolerates bounded runs of `prop` low. It counts violating samples, and latches a sticky failure with the cycle index at which the bound was exceeded. It gives simulation and emulation runs the same pass/fail verdict the formal property expresses, plus diagnostic counters.

## Interface
Parameters:
- `CW`, 8: width of the cycle index, the violation counter and the failure-cycle register.
- `LIMIT`, 2: maximum number of consecutive `prop`-low samples tolerated.
  - Legal range is 0 to 2^CW-2.
  - 0 means any low sample fails.

Ports:
- `clk`: input, 1. Single clock; everything samples on the rising edge.
- `reset`: input, 1. Asynchronous, active-low. Clears all state immediately on assertion; deassertion is synchronous to `clk`.
- `en`: input, 1. Arm request. Level-sensitive.
- `clear`: input, 1. Synchronous clear of verdict and counters. Highest synchronous priority.
- `prop`: input, 1. Property bit from the upstream counter stage.
- `busy`: output, 1. State is not IDLE.
- `fail`: output, 1. State is FAIL (sticky).
- `fail_cycle`: output, CW. Cycle index at which FAIL was entered.
- `viol_cnt`: output, CW. Saturating count of low `prop` samples taken while monitoring.
- `cyc`: output, CW. Saturating index of the current sample since arming.

## Operation
- States:
  - IDLE (00)
  - ARMED (01): watching, `prop` good.
  - PENDING (10): inside a low run.
  - FAIL (11)
- Internal `low_cnt`: width CW, number of consecutive low samples in the current run.
- Synchronous priority per edge, highest first:
  1. `clear` = 1: go to IDLE from any state. Zero `cyc`, `low_cnt`, `viol_cnt` and `fail_cycle`.
  2. FAIL: hold. `en` and `prop` are ignored; all counters are frozen.
  3. `en` = 0 in ARMED or PENDING: go to IDLE. Zero `low_cnt`. `cyc`, `viol_cnt` and `fail_cycle` hold.
  4. `prop` evaluation, as below.
- IDLE with `en` = 1: go to ARMED and set `cyc` <= 0. `viol_cnt` is zeroed on arming. `prop` is not evaluated on this edge.
- ARMED or PENDING with `en` = 1: `cyc` <= `cyc` + 1, saturating at 2^CW-1.
- ARMED transitions:
  - `prop` = 1: stay in ARMED.
  - `prop` = 0 and `LIMIT` = 0: go to FAIL.
  - `prop` = 0 otherwise: go to PENDING with `low_cnt` <= 1.
- PENDING transitions:
  - `prop` = 1: go to ARMED with `low_cnt` <= 0.
  - `prop` = 0 and `low_cnt` == `LIMIT`: go to FAIL.
  - `prop` = 0 otherwise: `low_cnt` <= `low_cnt` + 1.
- In effect, FAIL is entered on the (LIMIT+1)-th consecutive low sample.
- Every `prop` = 0 sample evaluated in ARMED or PENDING increments `viol_cnt`, saturating at 2^CW-1. This includes the sample that causes FAIL.
- On the edge entering FAIL: `fail_cycle` <= the current `cyc`, i.e. the value before the increment on that edge. `cyc` then freezes.
- `busy` = (state != IDLE); `fail` = (state == FAIL). Both are decoded from registered state, so no input reaches an output combinationally.

## Timing
- Reset values: state IDLE, `busy` 0, `fail` 0, `fail_cycle` 0, `viol_cnt` 0, `cyc` 0, `low_cnt` 0.
- Reset asserted mid-run, including in FAIL: all of the above take effect immediately, without waiting for a clock edge.
- Latency: a `prop` sample taken at edge N is reflected in `fail`, `viol_cnt` and `cyc` after edge N.
- The sample index k is the value of `cyc` at the edge where `prop` is evaluated. The first evaluated sample is the edge after arming, with `cyc` = 0.
- `en` dropping and `prop` low on the same edge: IDLE wins, and that sample is not counted.
- `clear` and the failing sample on the same edge: IDLE wins; `fail` never asserts.
- Saturated `cyc`: monitoring continues; `fail_cycle` records the saturated value.

## Test plan
- Reset, `en` = 1 at edge 0, `prop` = 1 for 10 edges -> `busy` 1, `fail` 0, `viol_cnt` 0, `cyc` 9.
- `LIMIT` = 2, `prop` low at samples 3–4, then high -> back to ARMED after sample 5, `viol_cnt` 2, `fail` 0.
- `LIMIT` = 2, `prop` low at samples 4, 5 and 6 -> `fail` 1 after sample 6, `fail_cycle` 6, `viol_cnt` 3. Values stay frozen for 5 further edges regardless of `en` and `prop`, then `clear` -> IDLE with all outputs 0.
- `LIMIT` = 0, single low at sample 2 -> FAIL, `fail_cycle` 2, `viol_cnt` 1.
- `CW` = 4, armed with `prop` = 1 for 20 edges -> `cyc` saturates at 15; a low at the 21st sample with `LIMIT` = 0 -> `fail_cycle` 15.
- `reset` asserted between edges while in PENDING with `viol_cnt` 1 -> all outputs 0 before the next edge. After release with `en` = 1: ARMED one edge later, `cyc` 0.
